// File: rtl/ex_mem_ctrl_stage.sv
// ex_mem_ctrl_stage: pipeline glue for the ARM-PPU core.
//   - combinational PC incrementer (next_pc = pc_in + PC_INC, carry dropped)
//   - combinational control bubble mux (nop_sel forces all id_* to zero)
//   - EX/MEM pipeline register with synchronous active-high clear (Clr)
// Optional build macro: EX_MEM_HOLD_EN adds a mem_hold input that freezes
// the EX/MEM register. Clr still wins over mem_hold.
// There is no handshake here: every stage moves on every rising Clk edge.
// The register captures unconditionally unless it is cleared or held.
module ex_mem_ctrl_stage #(
    parameter int PC_WIDTH   = 8,
    parameter int PC_INC     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Clr,
`ifdef EX_MEM_HOLD_EN
    input  logic                  mem_hold,
`endif
    // PC incrementer
    input  logic [PC_WIDTH-1:0]   pc_in,
    output logic [PC_WIDTH-1:0]   next_pc,
    // control unit outputs and bubble select
    input  logic [3:0]            cu_alu_op,
    input  logic [1:0]            cu_am,
    input  logic                  cu_b_instr,
    input  logic                  cu_bl_instr,
    input  logic                  cu_s,
    input  logic                  cu_load_instr,
    input  logic                  cu_rf_enable,
    input  logic                  cu_size,
    input  logic                  cu_rw,
    input  logic                  cu_e,
    input  logic                  nop_sel,
    output logic [3:0]            id_alu_op,
    output logic [1:0]            id_am,
    output logic                  id_b_instr,
    output logic                  id_bl_instr,
    output logic                  id_s,
    output logic                  id_load_instr,
    output logic                  id_rf_enable,
    output logic                  id_size,
    output logic                  id_rw,
    output logic                  id_e,
    // EX stage inputs
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic [DATA_WIDTH-1:0] ex_addr,
    input  logic [3:0]            ex_rd,
    input  logic                  ex_load_instr,
    input  logic                  ex_rf_enable,
    input  logic                  ex_size,
    input  logic                  ex_rw,
    input  logic                  ex_e,
    // MEM stage outputs
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_rd,
    output logic                  mem_load_instr,
    output logic                  mem_rf_enable,
    output logic                  mem_size,
    output logic                  mem_rw,
    output logic                  mem_e
);

    localparam logic [PC_WIDTH-1:0] PC_INC_W = PC_WIDTH'(PC_INC);

    // Next PC: modular add, the carry out is intentionally discarded.
    always_comb begin
        next_pc = pc_in + PC_INC_W;
    end

    // Bubble mux: a hazard turns the decoded instruction into an all-zero NOP.
    always_comb begin
        id_alu_op     = cu_alu_op;
        id_am         = cu_am;
        id_b_instr    = cu_b_instr;
        id_bl_instr   = cu_bl_instr;
        id_s          = cu_s;
        id_load_instr = cu_load_instr;
        id_rf_enable  = cu_rf_enable;
        id_size       = cu_size;
        id_rw         = cu_rw;
        id_e          = cu_e;
        if (nop_sel) begin
            id_alu_op     = 4'b0000;
            id_am         = 2'b00;
            id_b_instr    = 1'b0;
            id_bl_instr   = 1'b0;
            id_s          = 1'b0;
            id_load_instr = 1'b0;
            id_rf_enable  = 1'b0;
            id_size       = 1'b0;
            id_rw         = 1'b0;
            id_e          = 1'b0;
        end
    end

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            rd_q, rd_d;
    logic                  load_q, load_d;
    logic                  rfen_q, rfen_d;
    logic                  size_q, size_d;
    logic                  rw_q, rw_d;
    logic                  e_q, e_d;

    // EX/MEM next state: capture the EX stage, or recirculate when held.
    always_comb begin
        data_d = ex_data;
        addr_d = ex_addr;
        rd_d   = ex_rd;
        load_d = ex_load_instr;
        rfen_d = ex_rf_enable;
        size_d = ex_size;
        rw_d   = ex_rw;
        e_d    = ex_e;
`ifdef EX_MEM_HOLD_EN
        if (mem_hold) begin
            data_d = data_q;
            addr_d = addr_q;
            rd_d   = rd_q;
            load_d = load_q;
            rfen_d = rfen_q;
            size_d = size_q;
            rw_d   = rw_q;
            e_d    = e_q;
        end
`endif
    end

    // EX/MEM register: synchronous clear has priority over capture/hold.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            data_q <= '0;
            addr_q <= '0;
            rd_q   <= '0;
            load_q <= 1'b0;
            rfen_q <= 1'b0;
            size_q <= 1'b0;
            rw_q   <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            addr_q <= addr_d;
            rd_q   <= rd_d;
            load_q <= load_d;
            rfen_q <= rfen_d;
            size_q <= size_d;
            rw_q   <= rw_d;
            e_q    <= e_d;
        end
    end

    // Drive the MEM stage straight from the register.
    always_comb begin
        mem_data       = data_q;
        mem_addr       = addr_q;
        mem_rd         = rd_q;
        mem_load_instr = load_q;
        mem_rf_enable  = rfen_q;
        mem_size       = size_q;
        mem_rw         = rw_q;
        mem_e          = e_q;
    end

endmodule

// File: tb/tb_ex_mem_ctrl_stage.sv
// Testbench for ex_mem_ctrl_stage: directed vectors with hand-computed
// expectations pushed into a scoreboard queue and checked by a monitor.
// Build with +define+EX_MEM_HOLD_EN to exercise the hold feature as well.
module tb_ex_mem_ctrl_stage;

    localparam int W = 73;

    // kind: 0 = next_pc, 1 = id_* bundle, 2 = mem_* bundle
    typedef struct {
        int          kind;
        string       name;
        logic [W-1:0] exp;
    } exp_t;

    logic        Clk;
    logic        Clr;
`ifdef EX_MEM_HOLD_EN
    logic        mem_hold;
`endif
    logic [7:0]  pc_in, next_pc;
    logic [3:0]  cu_alu_op, id_alu_op;
    logic [1:0]  cu_am, id_am;
    logic        cu_b_instr, cu_bl_instr, cu_s, cu_load_instr;
    logic        cu_rf_enable, cu_size, cu_rw, cu_e, nop_sel;
    logic        id_b_instr, id_bl_instr, id_s, id_load_instr;
    logic        id_rf_enable, id_size, id_rw, id_e;
    logic [31:0] ex_data, ex_addr, mem_data, mem_addr;
    logic [3:0]  ex_rd, mem_rd;
    logic        ex_load_instr, ex_rf_enable, ex_size, ex_rw, ex_e;
    logic        mem_load_instr, mem_rf_enable, mem_size, mem_rw, mem_e;

    exp_t        exp_q[$];
    int          checks;
    int          failures;

    ex_mem_ctrl_stage dut (
        .Clk(Clk), .Clr(Clr),
`ifdef EX_MEM_HOLD_EN
        .mem_hold(mem_hold),
`endif
        .pc_in(pc_in), .next_pc(next_pc),
        .cu_alu_op(cu_alu_op), .cu_am(cu_am),
        .cu_b_instr(cu_b_instr), .cu_bl_instr(cu_bl_instr), .cu_s(cu_s),
        .cu_load_instr(cu_load_instr), .cu_rf_enable(cu_rf_enable),
        .cu_size(cu_size), .cu_rw(cu_rw), .cu_e(cu_e), .nop_sel(nop_sel),
        .id_alu_op(id_alu_op), .id_am(id_am),
        .id_b_instr(id_b_instr), .id_bl_instr(id_bl_instr), .id_s(id_s),
        .id_load_instr(id_load_instr), .id_rf_enable(id_rf_enable),
        .id_size(id_size), .id_rw(id_rw), .id_e(id_e),
        .ex_data(ex_data), .ex_addr(ex_addr), .ex_rd(ex_rd),
        .ex_load_instr(ex_load_instr), .ex_rf_enable(ex_rf_enable),
        .ex_size(ex_size), .ex_rw(ex_rw), .ex_e(ex_e),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_load_instr(mem_load_instr), .mem_rf_enable(mem_rf_enable),
        .mem_size(mem_size), .mem_rw(mem_rw), .mem_e(mem_e)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- driver tasks ----------------
    task automatic expect_pc(input string name, input logic [7:0] e);
        exp_t t;
        t.kind = 0; t.name = name; t.exp = W'(e);
        exp_q.push_back(t);
    endtask

    task automatic expect_id(input string name, input logic [13:0] e);
        exp_t t;
        t.kind = 1; t.name = name; t.exp = W'(e);
        exp_q.push_back(t);
    endtask

    // mem bundle: {data, addr, rd, load, rf_en, size, rw, e}
    task automatic expect_mem(input string name, input logic [31:0] d,
                              input logic [31:0] a, input logic [3:0] rd,
                              input logic [4:0] ctl);
        exp_t t;
        t.kind = 2; t.name = name; t.exp = {d, a, rd, ctl};
        exp_q.push_back(t);
    endtask

    task automatic drive_cu(input logic [3:0] op, input logic [1:0] am,
                            input logic [7:0] bits, input logic nop);
        cu_alu_op = op;
        cu_am     = am;
        {cu_b_instr, cu_bl_instr, cu_s, cu_load_instr,
         cu_rf_enable, cu_size, cu_rw, cu_e} = bits;
        nop_sel   = nop;
    endtask

    task automatic drive_ex(input logic [31:0] d, input logic [31:0] a,
                            input logic [3:0] rd, input logic [4:0] ctl);
        ex_data = d;
        ex_addr = a;
        ex_rd   = rd;
        {ex_load_instr, ex_rf_enable, ex_size, ex_rw, ex_e} = ctl;
    endtask

    // Wait until the monitor has drained everything issued so far.
    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            #1;
            budget++;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
            failures++;
            checks++;
            exp_q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t         t;
        logic [W-1:0] act;
        forever begin
            wait (exp_q.size() != 0);
            t = exp_q.pop_front();
            case (t.kind)
                0:       act = W'(next_pc);
                1:       act = W'({id_alu_op, id_am, id_b_instr, id_bl_instr,
                                   id_s, id_load_instr, id_rf_enable, id_size,
                                   id_rw, id_e});
                default: act = {mem_data, mem_addr, mem_rd, mem_load_instr,
                                mem_rf_enable, mem_size, mem_rw, mem_e};
            endcase
            checks++;
            if (act !== t.exp) begin
                failures++;
                $display("FAIL %s: actual=%h required=%h", t.name, act, t.exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        Clr      = 1'b1;
`ifdef EX_MEM_HOLD_EN
        mem_hold = 1'b0;
`endif
        pc_in = 8'h00;
        drive_cu(4'h0, 2'b00, 8'h00, 1'b0);
        drive_ex(32'hDEADBEEF, 32'h0, 4'h7, 5'b11111);

        // 1. PC incrementer, including the wrap.
        #1; expect_pc("pc_00", 8'h04); drain();
        pc_in = 8'h10; #1; expect_pc("pc_10", 8'h14); drain();
        pc_in = 8'hFC; #1; expect_pc("pc_fc_wrap", 8'h00); drain();
        pc_in = 8'hFF; #1; expect_pc("pc_ff_wrap", 8'h03); drain();

        // 2. Bubble mux pass and force-zero in the same timestep.
        drive_cu(4'hA, 2'b11, 8'hFF, 1'b0);
        #1; expect_id("id_pass_all_ones", {4'hA, 2'b11, 8'hFF}); drain();
        nop_sel = 1'b1;
        #0; expect_id("id_nop_all_ones", 14'h0); drain();
        drive_cu(4'h5, 2'b01, 8'hA5, 1'b0);
        #1; expect_id("id_pass_pattern", {4'h5, 2'b01, 8'hA5}); drain();
        nop_sel = 1'b1;
        #1; expect_id("id_nop_pattern", 14'h0); drain();

        // 3. Clear held over two edges with non-zero EX inputs.
        @(posedge Clk); #1;
        expect_mem("clr_edge1", 32'h0, 32'h0, 4'h0, 5'b00000); drain();
        @(posedge Clk); #1;
        expect_mem("clr_edge2", 32'h0, 32'h0, 4'h0, 5'b00000); drain();

        // 4. Capture with one-cycle latency.
        @(negedge Clk);
        Clr = 1'b0;
        drive_ex(32'h12345678, 32'h00000040, 4'h3, 5'b11001);
        #1; expect_mem("cap_not_before", 32'h0, 32'h0, 4'h0, 5'b00000); drain();
        @(posedge Clk); #1;
        expect_mem("cap_after_edge", 32'h12345678, 32'h00000040, 4'h3, 5'b11001); drain();

        // 5. Clr raised mid-cycle with inputs moving: no effect until edge.
        #2;
        Clr = 1'b1;
        drive_ex(32'hAAAA5555, 32'h11112222, 4'hE, 5'b10110);
        #1; expect_mem("clr_mid_a", 32'h12345678, 32'h00000040, 4'h3, 5'b11001); drain();
        drive_ex(32'h0F0F0F0F, 32'hF0F0F0F0, 4'h9, 5'b01010);
        #2; expect_mem("clr_mid_b", 32'h12345678, 32'h00000040, 4'h3, 5'b11001); drain();
        @(posedge Clk); #1;
        expect_mem("clr_mid_edge", 32'h0, 32'h0, 4'h0, 5'b00000); drain();

        // Resume on first edge with Clr low, then a second back-to-back load.
        @(negedge Clk);
        Clr = 1'b0;
        drive_ex(32'h0F0F0F0F, 32'hF0F0F0F0, 4'h9, 5'b01010);
        @(posedge Clk); #1;
        expect_mem("resume", 32'h0F0F0F0F, 32'hF0F0F0F0, 4'h9, 5'b01010); drain();
        @(negedge Clk);
        drive_ex(32'hFFFFFFFF, 32'h80000001, 4'hF, 5'b10101);
        @(posedge Clk); #1;
        expect_mem("back_to_back", 32'hFFFFFFFF, 32'h80000001, 4'hF, 5'b10101); drain();

`ifdef EX_MEM_HOLD_EN
        // 6. Hold freezes the register; Clr overrides hold.
        @(negedge Clk);
        drive_ex(32'hCAFEF00D, 32'h00000080, 4'h5, 5'b11111);
        @(posedge Clk); #1;
        expect_mem("hold_load", 32'hCAFEF00D, 32'h00000080, 4'h5, 5'b11111); drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            mem_hold = 1'b1;
            drive_ex(32'h1000 + 32'(i), 32'h2000 + 32'(i), 4'(i), 5'(i));
            @(posedge Clk); #1;
            expect_mem("hold_keep", 32'hCAFEF00D, 32'h00000080, 4'h5, 5'b11111); drain();
        end
        @(negedge Clk);
        Clr = 1'b1;
        @(posedge Clk); #1;
        expect_mem("hold_clr_priority", 32'h0, 32'h0, 4'h0, 5'b00000); drain();
        @(negedge Clk);
        Clr      = 1'b0;
        mem_hold = 1'b0;
        drive_ex(32'h00C0FFEE, 32'h4, 4'h2, 5'b00100);
        @(posedge Clk); #1;
        expect_mem("hold_release", 32'h00C0FFEE, 32'h4, 4'h2, 5'b00100); drain();
`endif

        // Combinational paths are independent of Clr.
        Clr   = 1'b1;
        pc_in = 8'h7C;
        drive_cu(4'h3, 2'b10, 8'h3C, 1'b0);
        #1; expect_pc("pc_under_clr", 8'h80); drain();
        expect_id("id_under_clr", {4'h3, 2'b10, 8'h3C}); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #20000;
        $display("FAIL global_timeout: time=%0t required_below=20000", $time);
        $fatal(1, "timeout");
    end

endmodule
